// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection light controller.
// Optional macro TRAFFIC_NIGHT_MODE_EN adds the FLASH state.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5
`ifdef TRAFFIC_NIGHT_MODE_EN
        ,
        FLASH     = 3'd6
`endif
    } state_t;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    function automatic logic is_green(state_t s);
        is_green = (s == NS_GREEN) || (s == EW_GREEN);
    endfunction

    function automatic logic is_all_red(state_t s);
        is_all_red = (s == ALL_RED_A) || (s == ALL_RED_B);
    endfunction

    function automatic state_t next_state(state_t s);
        next_state = ALL_RED_B;
        unique case (s)
            NS_GREEN:  next_state = NS_YELLOW;
            NS_YELLOW: next_state = ALL_RED_A;
            ALL_RED_A: next_state = EW_GREEN;
            EW_GREEN:  next_state = EW_YELLOW;
            EW_YELLOW: next_state = ALL_RED_B;
            ALL_RED_B: next_state = NS_GREEN;
            default:   next_state = ALL_RED_B;
        endcase
    endfunction

endpackage

// File: rtl/traffic_ctrl_fsm_edge_tick.sv
// Rising-edge detector: one-clk pulse per rising edge of a clk-domain input.
// A level already high when reset releases is not treated as an edge.
module edge_tick (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic tick
);

    logic in_q;
    logic armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            in_q  <= in;
            armed <= 1'b1;
        end
    end

    assign tick = in & ~in_q & armed;

endmodule

// File: rtl/traffic_ctrl_fsm.sv
// Two-way intersection light sequencer driven by divider clkdiv ticks.
// Optional macro TRAFFIC_NIGHT_MODE_EN adds a night input and FLASH state.
module traffic_ctrl_fsm
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS     = 10,
    parameter int YELLOW_TICKS    = 4,
    parameter int ALL_RED_TICKS   = 2,
    parameter int MIN_GREEN_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkdiv,
`ifdef TRAFFIC_NIGHT_MODE_EN
    input  logic       night,
`endif
    input  logic       ped_req,
    output logic       timer,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk
);

    localparam int WALK_TICKS = ALL_RED_TICKS + GREEN_TICKS / 2;
    localparam int MAX_A = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
    localparam int MAX_B = (MAX_A > ALL_RED_TICKS) ? MAX_A : ALL_RED_TICKS;
    localparam int MAX_T = (MAX_B > WALK_TICKS) ? MAX_B : WALK_TICKS;
    localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    state_t     state, nxt;
    cnt_t       tick_cnt, cnt_nxt, dur_m1;
    logic       ped_pending, pend_nxt;
    logic       walk_q, walk_nxt;
    logic       tick, last, early;
    logic [2:0] ns_d, ew_d;
    logic       timer_d;
`ifdef TRAFFIC_NIGHT_MODE_EN
    logic       flash_q, flash_nxt;
`endif

    edge_tick u_tick (
        .clk  (clk),
        .rst  (rst),
        .in   (clkdiv),
        .tick (tick)
    );

    // An all-red entered with a pending walk is stretched for the crossing.
    always_comb begin
        dur_m1 = cnt_t'(ALL_RED_TICKS - 1);
        unique case (state)
            NS_GREEN, EW_GREEN:   dur_m1 = cnt_t'(GREEN_TICKS - 1);
            NS_YELLOW, EW_YELLOW: dur_m1 = cnt_t'(YELLOW_TICKS - 1);
            ALL_RED_A, ALL_RED_B: dur_m1 = walk_q ? cnt_t'(WALK_TICKS - 1)
                                                  : cnt_t'(ALL_RED_TICKS - 1);
            default:              dur_m1 = '0;
        endcase
    end

    assign last  = (tick_cnt == dur_m1);
    assign early = is_green(state) && ped_pending &&
                   (tick_cnt >= cnt_t'(MIN_GREEN_TICKS - 1));

    always_comb begin
        nxt      = state;
        cnt_nxt  = tick_cnt;
        walk_nxt = walk_q;
        pend_nxt = ped_pending | ped_req;
`ifdef TRAFFIC_NIGHT_MODE_EN
        flash_nxt = flash_q;
`endif
        if (tick) begin
`ifdef TRAFFIC_NIGHT_MODE_EN
            if (night && state != FLASH) begin
                nxt       = FLASH;
                cnt_nxt   = '0;
                flash_nxt = 1'b1;
            end else if (state == FLASH) begin
                if (!night) begin
                    nxt     = ALL_RED_B;
                    cnt_nxt = '0;
                end else begin
                    flash_nxt = ~flash_q;
                end
            end else if (last || early) begin
                nxt     = next_state(state);
                cnt_nxt = '0;
            end else begin
                cnt_nxt = tick_cnt + 1'b1;
            end
`else
            if (last || early) begin
                nxt     = next_state(state);
                cnt_nxt = '0;
            end else begin
                cnt_nxt = tick_cnt + 1'b1;
            end
`endif
        end
        if (nxt != state) begin
            if (is_all_red(nxt)) begin
                walk_nxt = ped_pending;
                pend_nxt = ped_req;
            end else begin
                walk_nxt = 1'b0;
            end
        end
`ifdef TRAFFIC_NIGHT_MODE_EN
        if (state == FLASH || nxt == FLASH) begin
            pend_nxt = 1'b0;
            walk_nxt = 1'b0;
        end
`endif
    end

    always_comb begin
        ns_d    = LIGHT_OFF;
        ew_d    = LIGHT_OFF;
        timer_d = 1'b1;
        unique case (state)
            NS_GREEN:  begin ns_d = LIGHT_GRN; ew_d = LIGHT_RED; end
            NS_YELLOW: begin ns_d = LIGHT_YEL; ew_d = LIGHT_RED; timer_d = 1'b0; end
            EW_GREEN:  begin ns_d = LIGHT_RED; ew_d = LIGHT_GRN; end
            EW_YELLOW: begin ns_d = LIGHT_RED; ew_d = LIGHT_YEL; timer_d = 1'b0; end
            ALL_RED_A,
            ALL_RED_B: begin ns_d = LIGHT_RED; ew_d = LIGHT_RED; end
`ifdef TRAFFIC_NIGHT_MODE_EN
            FLASH: begin
                ns_d    = flash_q ? LIGHT_YEL : LIGHT_OFF;
                ew_d    = flash_q ? LIGHT_YEL : LIGHT_OFF;
                timer_d = 1'b0;
            end
`endif
            default:   begin ns_d = LIGHT_RED; ew_d = LIGHT_RED; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ALL_RED_B;
            tick_cnt    <= '0;
            ped_pending <= 1'b0;
            walk_q      <= 1'b0;
            ns_light    <= LIGHT_RED;
            ew_light    <= LIGHT_RED;
            timer       <= 1'b1;
            ped_walk    <= 1'b0;
        end else begin
            state       <= nxt;
            tick_cnt    <= cnt_nxt;
            ped_pending <= pend_nxt;
            walk_q      <= walk_nxt;
            ns_light    <= ns_d;
            ew_light    <= ew_d;
            timer       <= timer_d;
            ped_walk    <= walk_q;
        end
    end

`ifdef TRAFFIC_NIGHT_MODE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) flash_q <= 1'b0;
        else     flash_q <= flash_nxt;
    end
`endif

endmodule
